// File: rtl/fft_agu.sv
// Radix-2 DIT FFT sequencer: walks (level, fly), emits rotated read addresses,
// twiddle addresses, bank selects and the one-cycle-delayed write-back strobe.
module fft_agu #(
  parameter int N_LOG2 = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [N_LOG2-1:0] rd_adr_a,
  output logic [N_LOG2-1:0] rd_adr_b,
  output logic [N_LOG2-2:0] tw_adr,
  output logic              rd_bank,
  output logic [N_LOG2-1:0] wr_adr_a,
  output logic [N_LOG2-1:0] wr_adr_b,
  output logic              wr_bank,
  output logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic              result_bank
);

  localparam int FW = N_LOG2 - 1;
  localparam int LW = $clog2(N_LOG2);
  localparam logic [LW-1:0] LAST_LEVEL = LW'(N_LOG2 - 1);
  localparam logic RESULT_BANK = 1'(N_LOG2 % 2);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t            state, state_n;
  logic [LW-1:0]     level, level_n;
  logic [FW-1:0]     fly, fly_n;
  logic [N_LOG2-1:0] rd_adr_a_n, rd_adr_b_n;
  logic [FW-1:0]     tw_adr_n;
  logic              rd_bank_n, wr_en_n, busy_n, done_n;

  // Left-circular rotation within N_LOG2 bits.
  function automatic logic [N_LOG2-1:0] rotl(input logic [N_LOG2-1:0] x, input logic [LW-1:0] s);
    logic [2*N_LOG2-1:0] d;
    d = {x, x} << s;
    return d[2*N_LOG2-1:N_LOG2];
  endfunction

  // Twiddle index keeps only the top 'level' bits of fly.
  function automatic logic [FW-1:0] tw_of(input logic [FW-1:0] f, input logic [LW-1:0] l);
    logic [FW-1:0] mask;
    mask = {FW{1'b1}} << (LAST_LEVEL - l);
    return f & mask;
  endfunction

  assign result_bank = RESULT_BANK;

  // State, counters and all output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      level    <= '0;
      fly      <= '0;
      rd_adr_a <= '0;
      rd_adr_b <= '0;
      tw_adr   <= '0;
      rd_bank  <= 1'b0;
      wr_adr_a <= '0;
      wr_adr_b <= '0;
      wr_bank  <= 1'b0;
      wr_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      level    <= level_n;
      fly      <= fly_n;
      rd_adr_a <= rd_adr_a_n;
      rd_adr_b <= rd_adr_b_n;
      tw_adr   <= tw_adr_n;
      rd_bank  <= rd_bank_n;
      wr_adr_a <= rd_adr_a;
      wr_adr_b <= rd_adr_b;
      wr_bank  <= ~rd_bank;
      wr_en    <= wr_en_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  // Next state and counter advance; counters sit at zero outside RUN.
  always_comb begin
    state_n = state;
    level_n = '0;
    fly_n   = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (fly == {FW{1'b1}}) begin
          fly_n = '0;
          if (level == LAST_LEVEL) begin
            state_n = FLUSH;
            level_n = '0;
          end else begin
            state_n = RUN;
            level_n = level + LW'(1);
          end
        end else begin
          fly_n   = fly + FW'(1);
          level_n = level;
        end
      end
      FLUSH:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from next-state counters.
  always_comb begin
    rd_adr_a_n = rotl({fly_n, 1'b0}, level_n);
    rd_adr_b_n = rotl({fly_n, 1'b1}, level_n);
    tw_adr_n   = tw_of(fly_n, level_n);
    rd_bank_n  = level_n[0];
    wr_en_n    = (state == RUN);
    busy_n     = (state_n == RUN) || (state_n == FLUSH);
    done_n     = (state_n == DONE);
  end

endmodule

// File: tb/tb_fft_agu.sv
// Randomized bench for fft_agu (N_LOG2=3) against a cycle-phase reference model.
module tb_fft_agu;

  localparam int W = 3;
  localparam int N = 1 << W;
  localparam int H = N / 2;
  localparam int M = W * H;

  logic         clk = 1'b0;
  logic         reset_n, start;
  logic [W-1:0] rd_adr_a, rd_adr_b, wr_adr_a, wr_adr_b;
  logic [W-2:0] tw_adr;
  logic         rd_bank, wr_bank, wr_en, busy, done, result_bank;

  int n_checks = 0;
  int n_errors = 0;
  int ph = -1;
  bit after_rst = 1'b0;
  int dut_wr = 0;

  int tab_a [12] = '{0, 2, 4, 6, 0, 4, 1, 5, 0, 1, 2, 3};
  int tab_b [12] = '{1, 3, 5, 7, 2, 6, 3, 7, 4, 5, 6, 7};
  int tab_tw[12] = '{0, 0, 0, 0, 0, 0, 2, 2, 0, 1, 2, 3};
  int tab_bk[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

  fft_agu #(.N_LOG2(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .rd_adr_a(rd_adr_a), .rd_adr_b(rd_adr_b), .tw_adr(tw_adr), .rd_bank(rd_bank),
    .wr_adr_a(wr_adr_a), .wr_adr_b(wr_adr_b), .wr_bank(wr_bank), .wr_en(wr_en),
    .busy(busy), .done(done), .result_bank(result_bank)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s ph=%0d got=%0d expected=%0d", tag, ph, act, exp);
    end
  endtask

  function automatic int rotl(input int x, input int l);
    return ((x << l) | (x >> (W - l))) % N;
  endfunction

  // Reference values for issue number i (0..M-1).
  function automatic int ref_a(input int i);
    return rotl(2 * (i % H), i / H);
  endfunction
  function automatic int ref_b(input int i);
    return rotl(2 * (i % H) + 1, i / H);
  endfunction
  function automatic int ref_tw(input int i);
    return (i % H) & (((H - 1) << (W - 1 - i / H)) % H);
  endfunction
  function automatic int ref_bank(input int i);
    return (i / H) % 2;
  endfunction

  task automatic compare();
    int i;
    if (ph >= 1 && ph <= M) begin
      i = ph - 1;
      check_val("rd_a", int'(rd_adr_a), ref_a(i));
      check_val("rd_b", int'(rd_adr_b), ref_b(i));
      check_val("tw", int'(tw_adr), ref_tw(i));
      check_val("rd_bank", int'(rd_bank), ref_bank(i));
      check_val("tab_a", int'(rd_adr_a), tab_a[i]);
      check_val("tab_b", int'(rd_adr_b), tab_b[i]);
      check_val("tab_tw", int'(tw_adr), tab_tw[i]);
      check_val("tab_bank", int'(rd_bank), tab_bk[i]);
    end else begin
      check_val("idle_rd_a", int'(rd_adr_a), 0);
      check_val("idle_rd_b", int'(rd_adr_b), after_rst ? 0 : 1);
      check_val("idle_tw", int'(tw_adr), 0);
      check_val("idle_rd_bank", int'(rd_bank), 0);
    end
    check_val("busy", int'(busy), (ph >= 1 && ph <= M + 1) ? 1 : 0);
    check_val("done", int'(done), (ph == M + 2) ? 1 : 0);
    check_val("wr_en", int'(wr_en), (ph >= 2 && ph <= M + 1) ? 1 : 0);
    if (ph >= 2 && ph <= M + 1) begin
      i = ph - 2;
      check_val("wr_a", int'(wr_adr_a), ref_a(i));
      check_val("wr_b", int'(wr_adr_b), ref_b(i));
      check_val("wr_bank", int'(wr_bank), 1 - ref_bank(i));
    end else if (after_rst) begin
      check_val("rst_wr_a", int'(wr_adr_a), 0);
      check_val("rst_wr_b", int'(wr_adr_b), 0);
      check_val("rst_wr_bank", int'(wr_bank), 0);
    end
    if (ph == 1) dut_wr = 0;
    if (wr_en) dut_wr++;
    if (ph == M + 2) begin
      check_val("wr_count", dut_wr, M);
      check_val("result_bank", int'(result_bank), W % 2);
    end
  endtask

  // Apply inputs for the next rising edge, advance the model, then check at the falling edge.
  task automatic step(input logic s, input logic r);
    start   = s;
    reset_n = r;
    if (!r) begin
      ph = -1;
      after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      if (ph < 0) begin
        if (s) ph = 1;
      end else begin
        ph++;
        if (ph > M + 2) ph = -1;
      end
    end
    @(negedge clk);
    compare();
  endtask

  initial begin
    start   = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    // Start at k; stray starts at k+5 and k+14; new run at k+15.
    step(1'b1, 1'b1);
    for (int j = 1; j <= 14; j++) step((j == 5 || j == 14) ? 1'b1 : 1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int j = 1; j <= 15; j++) step(1'b0, 1'b1);
    // Reset at the edge ending issue 7, then a quiet period and a full run.
    step(1'b1, 1'b1);
    for (int j = 1; j <= 6; j++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    for (int j = 1; j <= 20; j++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int j = 1; j <= 14; j++) step(1'b0, 1'b1);
    // Back-to-back: restart in the first IDLE cycle.
    step(1'b1, 1'b1);
    for (int j = 1; j <= 14; j++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int j = 1; j <= 15; j++) step(1'b0, 1'b1);
    // Random starts and occasional resets.
    for (int j = 0; j < 800; j++)
      step(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
